line_win_rd_ctrl: RTL and testbench
===================================

LINE_WIN_RD_CTRL -- requirements
Module: line_win_rd_ctrl

Interface
REQ-001: Parameter IMAGE_WIDTH, default 28, is the pixels per row and the read burst length.
REQ-002: Parameter IMAGE_HEIGHT, default 28, is the rows per frame.
REQ-003: Parameter FIRST_BANK, default 3, is the line bank that receives row 0; row r resides in bank (FIRST_BANK+r) mod 4.
REQ-004: Port clk, input, 1 bit, is the single clock; all logic SHALL be on its rising edge.
REQ-005: Port RESET, input, 1 bit, is the reset, synchronous and active-high.
REQ-006: Port frame_start, input, 1 bit, is a one-cycle pulse that begins a frame.
REQ-007: Port row_done, input, 1 bit, is a one-cycle pulse from the writer meaning one full row is stored.
REQ-008: Port rd_ready, input, 1 bit, means downstream can accept one row burst.
REQ-009: Port rd_addr, output, 11 bits, is the shared read address for the line banks.
REQ-010: Ports in0_rden, in1_rden, in2_rden and in3_rden, outputs, 1 bit each, are the per-bank read enables.
REQ-011: Ports top_sel, mid_sel and bot_sel, outputs, 2 bits each, give the bank index holding the window rows r, r+1 and r+2.
REQ-012: Port win_valid, output, 1 bit, marks bank q data valid.
REQ-013: Port win_col, output, 11 bits, is the column of the current win_valid beat.
REQ-014: Port out_row, output, 11 bits, is the window row r currently being read.
REQ-015: Port frame_done, output, 1 bit, is a one-cycle pulse at frame end.
REQ-016: Port overrun, output, 1 bit, is a sticky error flag.

Function
REQ-017: The FSM SHALL have the states IDLE, FILL, WAIT, READ and DONE.
REQ-018: IDLE SHALL move to FILL on frame_start and clear rows_written, rows_avail, out_row and overrun.
REQ-019: FILL SHALL count row_done; when rows_written reaches 3, it SHALL set rows_avail=1 and move to WAIT.
REQ-020: Each later row_done SHALL increment rows_written and rows_avail.
REQ-021: WAIT SHALL move to READ when rows_avail>0 and rd_ready=1, decrementing rows_avail in the same cycle.
REQ-022: On entry to READ, top_sel, mid_sel and bot_sel SHALL latch the banks of rows out_row, out_row+1 and out_row+2 and hold them for the burst.
REQ-023: READ SHALL drive rd_addr 0..IMAGE_WIDTH-1, one per cycle, with no stall.
REQ-024: During READ, exactly the three selected rden SHALL be 1 and the fourth (write) bank rden SHALL be 0.
REQ-025: win_valid SHALL equal READ rden delayed by 1 cycle (BRAM latency), and win_col SHALL equal rd_addr delayed by 1 cycle.
REQ-026: At rd_addr=IMAGE_WIDTH-1, out_row SHALL increment.
REQ-027: At the end of a burst, if the new out_row equals IMAGE_HEIGHT-2, the FSM SHALL go to DONE; otherwise it SHALL go to WAIT.
REQ-028: DONE SHALL pulse frame_done for 1 cycle and then go to IDLE.
REQ-029: A row_done coincident with a burst start SHALL net rows_avail unchanged.
REQ-030: rows_avail>1 SHALL set overrun (writer about to overwrite the top bank); overrun SHALL hold until RESET or frame_start.
REQ-031: row_done in IDLE or DONE SHALL be ignored.
REQ-032: frame_start in any non-IDLE state SHALL abort the frame, clear the counters, force all rden=0, and enter FILL next cycle.
REQ-033: Bank arithmetic SHALL be 2-bit modulo-4 wrap.
REQ-034: rd_addr SHALL wrap to 0 after each burst.
REQ-035: rd_addr SHALL hold 0 outside READ.

Reset
REQ-036: RESET SHALL take priority over frame_start.
REQ-037: While RESET=1: state IDLE; rd_addr=0; all rden=0; win_valid=0; win_col=0; out_row=0; frame_done=0; overrun=0.
REQ-038: While RESET=1: top_sel=FIRST_BANK, mid_sel=FIRST_BANK+1, bot_sel=FIRST_BANK+2 (mod 4).
REQ-039: RESET asserted mid-burst SHALL give these values on the next edge, with no partial burst resumed.

Structure
REQ-040: A shared package SHALL hold the FSM state encoding, the 11-bit address width constant and the bank-index width.
REQ-041: One sub-module, line_rd_addr_gen, SHALL implement the burst address counter with a last-beat flag.
REQ-042: The FSM and bank mapping SHALL stay in the top module.

Verification
REQ-043: Defaults, rd_ready=1, frame_start, then 3 row_done pulses -> READ within 2 cycles, selects 3/0/1, in0/in1/in3_rden=1, in2_rden=0, 28 consecutive addresses 0..27.
REQ-044: Full frame of 28 row_done pulses spaced 40 cycles -> exactly 26 bursts, bot_sel sequence 1,2,3,0,..., one frame_done after burst 26.
REQ-045: rd_ready=0 after fill, then 2 further row_done -> no rden, overrun=1; rd_ready=1 -> bursts proceed, overrun stays 1.
REQ-046: row_done on the cycle of the WAIT->READ transition -> rows_avail unchanged, next burst starts directly after the current one.
REQ-047: frame_start at burst beat 10 -> rden=0 next cycle, out_row=0, FILL re-entered, 3 new row_done -> selects 3/0/1 again.
REQ-048: RESET at beat 5 together with frame_start -> IDLE with all outputs at reset values, no FILL entry.

Source files
------------

// File: rtl/line_win_rd_ctrl_pkg.sv
// Shared constants for the line-window read controller: FSM encoding,
// address/row width and line-bank index width, plus the bank mapping helper.
package line_win_rd_ctrl_pkg;

    localparam int ADDR_W  = 11;
    localparam int BANK_W  = 2;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_FILL = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] S_READ = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE = 3'd4;

    // Bank holding (row + ofs); the 2-bit sum wraps modulo 4 by construction.
    function automatic logic [BANK_W-1:0] bank_of(
        input logic [BANK_W-1:0] base,
        input logic [BANK_W-1:0] row_lo,
        input logic [BANK_W-1:0] ofs
    );
        return base + row_lo + ofs;
    endfunction

endpackage

// File: rtl/line_rd_addr_gen.sv
// Burst column counter: counts 0..IMAGE_WIDTH-1 while en, one per cycle, then wraps to 0.
// Zero latency on last (combinational); no stall input, the burst always runs to completion unless cleared.
module line_rd_addr_gen
    import line_win_rd_ctrl_pkg::*;
#(
    parameter int IMAGE_WIDTH = 28
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              clear,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    assign last = en && (addr == ADDR_W'(IMAGE_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (RESET || clear) begin
            addr <= '0;
        end else if (last) begin
            addr <= '0;
        end else if (en) begin
            addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/line_win_rd_ctrl.sv
// Sequences 3-row window bursts out of a 4-bank line buffer as the writer completes rows.
// Window data lands 1 cycle after rd_addr; a burst starts only when rd_ready=1 and then never stalls.
module line_win_rd_ctrl
    import line_win_rd_ctrl_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 28,
    parameter int IMAGE_HEIGHT = 28,
    parameter int FIRST_BANK   = 3
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              frame_start,
    input  logic              row_done,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              in0_rden,
    output logic              in1_rden,
    output logic              in2_rden,
    output logic              in3_rden,
    output logic [BANK_W-1:0] top_sel,
    output logic [BANK_W-1:0] mid_sel,
    output logic [BANK_W-1:0] bot_sel,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_col,
    output logic [ADDR_W-1:0] out_row,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [BANK_W-1:0] BANK0    = BANK_W'(FIRST_BANK % 4);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMAGE_HEIGHT - 2);

    logic [STATE_W-1:0] state;
    logic [ADDR_W-1:0]  rows_written;
    logic [ADDR_W-1:0]  rows_avail;
    logic [ADDR_W-1:0]  next_row;
    logic               in_read;
    logic               burst_start;
    logic               row_inc;
    logic               last_beat;
    logic [3:0]         rden;

    assign in_read     = (state == S_READ);
    assign burst_start = (state == S_WAIT) && (rows_avail != '0) && rd_ready;
    assign row_inc     = row_done && ((state == S_WAIT) || (state == S_READ));
    assign next_row    = out_row + 1'b1;
    assign frame_done  = (state == S_DONE);

    line_rd_addr_gen #(
        .IMAGE_WIDTH (IMAGE_WIDTH)
    ) u_addr_gen (
        .clk   (clk),
        .RESET (RESET),
        .clear (frame_start),
        .en    (in_read),
        .addr  (rd_addr),
        .last  (last_beat)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            state        <= S_IDLE;
            rows_written <= '0;
            rows_avail   <= '0;
            out_row      <= '0;
            overrun      <= 1'b0;
            top_sel      <= bank_of(BANK0, 2'd0, 2'd0);
            mid_sel      <= bank_of(BANK0, 2'd0, 2'd1);
            bot_sel      <= bank_of(BANK0, 2'd0, 2'd2);
            win_valid    <= 1'b0;
            win_col      <= '0;
        end else begin
            win_valid <= in_read;
            win_col   <= rd_addr;
            // frame_start restarts from any state, including an in-flight burst
            if (frame_start) begin
                state        <= S_FILL;
                rows_written <= '0;
                rows_avail   <= '0;
                out_row      <= '0;
                overrun      <= 1'b0;
            end else begin
                if (rows_avail > ADDR_W'(1)) begin
                    overrun <= 1'b1;
                end
                case (state)
                    S_IDLE: ;
                    S_FILL: begin
                        if (row_done) begin
                            rows_written <= rows_written + 1'b1;
                            if (rows_written == ADDR_W'(2)) begin
                                rows_avail <= ADDR_W'(1);
                                state      <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT, S_READ: begin
                        rows_written <= rows_written + ADDR_W'(row_inc);
                        rows_avail   <= rows_avail + ADDR_W'(row_inc) - ADDR_W'(burst_start);
                        if (burst_start) begin
                            state   <= S_READ;
                            top_sel <= bank_of(BANK0, out_row[BANK_W-1:0], 2'd0);
                            mid_sel <= bank_of(BANK0, out_row[BANK_W-1:0], 2'd1);
                            bot_sel <= bank_of(BANK0, out_row[BANK_W-1:0], 2'd2);
                        end
                        if (last_beat) begin
                            out_row <= next_row;
                            state   <= (next_row == LAST_ROW) ? S_DONE : S_WAIT;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The three window banks are distinct mod 4, so exactly one bank stays free for the writer.
    always_comb begin
        rden = '0;
        if (in_read) begin
            rden[top_sel] = 1'b1;
            rden[mid_sel] = 1'b1;
            rden[bot_sel] = 1'b1;
        end
    end

    assign {in3_rden, in2_rden, in1_rden, in0_rden} = rden;

endmodule

// File: tb/tb_line_win_rd_ctrl.sv
// Directed bench for line_win_rd_ctrl; expected bursts are queued as rows are written
// and checked beat by beat by a negedge monitor.
module tb_line_win_rd_ctrl;

    localparam int W  = 28;
    localparam int FB = 3;

    typedef struct packed {
        logic [1:0]  t;
        logic [1:0]  m;
        logic [1:0]  b;
        logic [10:0] row;
    } exp_t;

    logic        clk = 1'b0;
    logic        RESET;
    logic        frame_start;
    logic        row_done;
    logic        rd_ready;
    logic [10:0] rd_addr;
    logic        in0_rden, in1_rden, in2_rden, in3_rden;
    logic [1:0]  top_sel, mid_sel, bot_sel;
    logic        win_valid;
    logic [10:0] win_col;
    logic [10:0] out_row;
    logic        frame_done;
    logic        overrun;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t cur = '0;
    int   beat = 0;
    int   bursts = 0;
    int   gap = 0;
    int   last_gap = 0;
    int   fd_cnt = 0;
    int   bursts_at_fd = 0;
    logic abort_ok = 1'b0;
    logic prev_rden = 1'b0;
    logic prev_reset = 1'b1;
    logic [10:0] prev_addr = '0;
    logic [3:0]  vec;
    int   lat;
    int   b0;

    line_win_rd_ctrl dut (
        .clk         (clk),
        .RESET       (RESET),
        .frame_start (frame_start),
        .row_done    (row_done),
        .rd_ready    (rd_ready),
        .rd_addr     (rd_addr),
        .in0_rden    (in0_rden),
        .in1_rden    (in1_rden),
        .in2_rden    (in2_rden),
        .in3_rden    (in3_rden),
        .top_sel     (top_sel),
        .mid_sel     (mid_sel),
        .bot_sel     (bot_sel),
        .win_valid   (win_valid),
        .win_col     (win_col),
        .out_row     (out_row),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_vec(input exp_t e);
        logic [3:0] v;
        v = '0;
        v[e.t] = 1'b1;
        v[e.m] = 1'b1;
        v[e.b] = 1'b1;
        return v;
    endfunction

    function automatic logic rden_any();
        return in0_rden | in1_rden | in2_rden | in3_rden;
    endfunction

    task automatic push_burst(input int row);
        exp_t e;
        e.t   = 2'((FB + row) % 4);
        e.m   = 2'((FB + row + 1) % 4);
        e.b   = 2'((FB + row + 2) % 4);
        e.row = 11'(row);
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic pulse_row(input int gap_cycles);
        row_done = 1'b1;
        tick(1);
        row_done = 1'b0;
        tick(gap_cycles);
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({p, "_rden"}, 32'({in3_rden, in2_rden, in1_rden, in0_rden}), 32'd0);
        chk({p, "_win_valid"}, 32'(win_valid), 32'd0);
        chk({p, "_win_col"}, 32'(win_col), 32'd0);
        chk({p, "_out_row"}, 32'(out_row), 32'd0);
        chk({p, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({p, "_overrun"}, 32'(overrun), 32'd0);
        chk({p, "_top_sel"}, 32'(top_sel), 32'd3);
        chk({p, "_mid_sel"}, 32'(mid_sel), 32'd0);
        chk({p, "_bot_sel"}, 32'(bot_sel), 32'd1);
    endtask

    // Beat-level monitor: data-valid/column pipeline, burst contents and burst length.
    always @(negedge clk) begin
        vec = {in3_rden, in2_rden, in1_rden, in0_rden};
        chk("win_valid", 32'(win_valid), 32'(prev_rden && !prev_reset));
        chk("win_col", 32'(win_col), prev_reset ? 32'd0 : 32'(prev_addr));
        if (frame_done) begin
            fd_cnt++;
            bursts_at_fd = bursts;
        end
        if (vec != 4'd0) begin
            if (beat == 0) begin
                last_gap = gap;
                gap = 0;
                chk("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    cur = sb_q.pop_front();
                    chk("burst_out_row", 32'(out_row), 32'(cur.row));
                    chk("burst_top_sel", 32'(top_sel), 32'(cur.t));
                    chk("burst_mid_sel", 32'(mid_sel), 32'(cur.m));
                    chk("burst_bot_sel", 32'(bot_sel), 32'(cur.b));
                end
            end
            chk("rden_vec", 32'(vec), 32'(exp_vec(cur)));
            chk("rd_addr_beat", 32'(rd_addr), 32'(beat));
            beat++;
            if (beat == W) begin
                bursts++;
                beat = 0;
            end
        end else begin
            if (beat != 0 && !abort_ok) chk("burst_len", 32'(beat), 32'(W));
            beat = 0;
            gap++;
            chk("rd_addr_idle", 32'(rd_addr), 32'd0);
        end
        prev_rden  = (vec != 4'd0);
        prev_addr  = rd_addr;
        prev_reset = RESET;
    end

    initial begin
        RESET = 1'b1;
        frame_start = 1'b0;
        row_done = 1'b0;
        rd_ready = 1'b1;
        tick(3);
        chk_reset_vals("rst");
        RESET = 1'b0;
        tick(2);

        // Full frame, rows every 40 cycles
        pulse_fs();
        for (int r = 1; r <= 28; r++) begin
            if (r >= 3) push_burst(r - 3);
            row_done = 1'b1;
            tick(1);
            row_done = 1'b0;
            if (r == 3) begin
                lat = 1;
                while (!rden_any() && lat < 10) begin
                    tick(1);
                    lat++;
                end
                chk("fill_to_read_latency", 32'(lat), 32'd2);
                chk("first_in2_rden", 32'(in2_rden), 32'd0);
                chk("first_in013_rden", 32'({in3_rden, in1_rden, in0_rden}), 32'h7);
            end
            tick(39);
        end
        tick(40);
        chk("frame_bursts", 32'(bursts), 32'd26);
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
        chk("frame_done_after_last", 32'(bursts_at_fd), 32'd26);
        chk("frame_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("frame_overrun", 32'(overrun), 32'd0);
        chk("frame_out_row", 32'(out_row), 32'd26);

        // Downstream stalled: rows pile up and overrun latches
        b0 = bursts;
        rd_ready = 1'b0;
        pulse_fs();
        for (int r = 1; r <= 5; r++) begin
            if (r >= 3) push_burst(r - 3);
            pulse_row(4);
        end
        tick(5);
        chk("stall_rden", 32'(rden_any()), 32'd0);
        chk("stall_bursts", 32'(bursts - b0), 32'd0);
        chk("stall_overrun", 32'(overrun), 32'd1);
        rd_ready = 1'b1;
        tick(110);
        chk("drain_bursts", 32'(bursts - b0), 32'd3);
        chk("drain_overrun_sticky", 32'(overrun), 32'd1);
        chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);

        // row_done coincident with WAIT->READ
        b0 = bursts;
        pulse_fs();
        tick(1);
        chk("restart_overrun_clr", 32'(overrun), 32'd0);
        pulse_row(4);
        pulse_row(4);
        push_burst(0);
        push_burst(1);
        row_done = 1'b1;
        tick(1);
        tick(1);
        row_done = 1'b0;
        tick(70);
        chk("coinc_bursts", 32'(bursts - b0), 32'd2);
        chk("coinc_gap", 32'(last_gap), 32'd1);
        chk("coinc_overrun", 32'(overrun), 32'd0);
        chk("coinc_sb_empty", 32'(sb_q.size()), 32'd0);

        // frame_start at beat 10 of the second burst
        b0 = bursts;
        pulse_fs();
        for (int r = 1; r <= 4; r++) begin
            if (r >= 3) push_burst(r - 3);
            pulse_row(4);
        end
        lat = 0;
        while (!(rden_any() && out_row == 11'd1 && rd_addr == 11'd10) && lat < 300) begin
            tick(1);
            lat++;
        end
        chk("abort_point_found", 32'(lat < 300), 32'd1);
        abort_ok = 1'b1;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("abort_rden", 32'(rden_any()), 32'd0);
        chk("abort_out_row", 32'(out_row), 32'd0);
        chk("abort_rd_addr", 32'(rd_addr), 32'd0);
        pulse_row(4);
        pulse_row(4);
        chk("abort_refill_rden", 32'(rden_any()), 32'd0);
        chk("abort_refill_bursts", 32'(bursts - b0), 32'd1);
        abort_ok = 1'b0;
        push_burst(0);
        pulse_row(40);
        chk("abort_rerun_bursts", 32'(bursts - b0), 32'd2);
        chk("abort_rerun_top", 32'(top_sel), 32'd3);
        chk("abort_rerun_mid", 32'(mid_sel), 32'd0);
        chk("abort_rerun_bot", 32'(bot_sel), 32'd1);
        chk("abort_sb_empty", 32'(sb_q.size()), 32'd0);

        // RESET together with frame_start at beat 5 of the second burst
        b0 = bursts;
        pulse_fs();
        for (int r = 1; r <= 4; r++) begin
            if (r >= 3) push_burst(r - 3);
            pulse_row(4);
        end
        lat = 0;
        while (!(rden_any() && out_row == 11'd1 && rd_addr == 11'd5) && lat < 300) begin
            tick(1);
            lat++;
        end
        chk("reset_point_found", 32'(lat < 300), 32'd1);
        abort_ok = 1'b1;
        RESET = 1'b1;
        frame_start = 1'b1;
        tick(1);
        chk_reset_vals("rst_mid");
        RESET = 1'b0;
        frame_start = 1'b0;
        tick(3);
        for (int r = 1; r <= 3; r++) pulse_row(4);
        tick(40);
        chk("rst_no_fill_bursts", 32'(bursts - b0), 32'd1);
        chk("rst_no_fill_rden", 32'(rden_any()), 32'd0);
        chk("rst_sb_empty", 32'(sb_q.size()), 32'd0);
        abort_ok = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
